// File: rtl/debounce_pkg.sv
// Shared types and default constants for the switch debouncer and its settle-timer sequencing.
package debounce_pkg;

    localparam int unsigned         DEF_CNT_W      = 8;
    localparam logic [DEF_CNT_W-1:0] DEF_SETTLE_CNT = 8'h0A;
    localparam int unsigned         DEF_BOUNCE_W   = 8;

    typedef enum logic {
        STABLE = 1'b0,
        WAIT   = 1'b1
    } db_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for an asynchronous pin, with a selectable synchronous reset value.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/debounce_ctrl.sv
// Switch debouncer that drives an external down-counter as its settle timer and
// produces a clean level, edge ticks and a saturating count of rejected bounces.
module debounce_ctrl
    import debounce_pkg::*;
#(
    parameter int unsigned      CNT_W      = DEF_CNT_W,
    parameter logic [CNT_W-1:0] SETTLE_CNT = CNT_W'(DEF_SETTLE_CNT),
    parameter logic             INIT_LEVEL = 1'b0,
    parameter int unsigned      BOUNCE_W   = DEF_BOUNCE_W
) (
    input  logic                sysclk,
    input  logic                reset,
    input  logic                sw_i,
    output logic                cnt_load,
    output logic                cnt_en,
    output logic                cnt_up,
    output logic [CNT_W-1:0]    cnt_d,
    input  logic                cnt_min_tick,
    output logic                db_level_o,
    output logic                rise_tick_o,
    output logic                fall_tick_o,
    output logic [BOUNCE_W-1:0] bounce_cnt_o
);

    localparam logic [BOUNCE_W-1:0] BOUNCE_MAX = {BOUNCE_W{1'b1}};

    db_state_t           r_state;
    db_state_t           w_state_nxt;
    logic                w_sw_s;
    logic                w_commit;
    logic                w_abort;
    logic                r_db_level;
    logic                r_rise_tick;
    logic                r_fall_tick;
    logic [BOUNCE_W-1:0] r_bounce_cnt;

    sync_2ff #(
        .RST_VAL (INIT_LEVEL)
    ) u_sync (
        .i_clk (sysclk),
        .i_rst (reset),
        .i_d   (sw_i),
        .o_q   (w_sw_s)
    );

    // Counter always counts down from the fixed settle preload.
    assign cnt_up = 1'b0;
    assign cnt_d  = SETTLE_CNT;

    always_ff @(posedge sysclk) begin
        if (reset) begin
            r_state <= STABLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Abort takes priority over commit so a late revert never produces a tick.
    always_comb begin
        w_state_nxt = r_state;
        cnt_load    = 1'b0;
        cnt_en      = 1'b0;
        w_commit    = 1'b0;
        w_abort     = 1'b0;
        unique case (r_state)
            STABLE: begin
                if (w_sw_s != r_db_level) begin
                    cnt_load    = 1'b1;
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (w_sw_s == r_db_level) begin
                    w_abort     = 1'b1;
                    w_state_nxt = STABLE;
                end else if (cnt_min_tick) begin
                    w_commit    = 1'b1;
                    w_state_nxt = STABLE;
                end else begin
                    cnt_en      = 1'b1;
                end
            end
            default: begin
                w_state_nxt = STABLE;
            end
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            r_db_level   <= INIT_LEVEL;
            r_rise_tick  <= 1'b0;
            r_fall_tick  <= 1'b0;
            r_bounce_cnt <= '0;
        end else begin
            r_rise_tick <= w_commit & w_sw_s;
            r_fall_tick <= w_commit & ~w_sw_s;
            if (w_commit) begin
                r_db_level <= w_sw_s;
            end
            if (w_abort && (r_bounce_cnt != BOUNCE_MAX)) begin
                r_bounce_cnt <= r_bounce_cnt + BOUNCE_W'(1);
            end
        end
    end

    assign db_level_o   = r_db_level;
    assign rise_tick_o  = r_rise_tick;
    assign fall_tick_o  = r_fall_tick;
    assign bounce_cnt_o = r_bounce_cnt;

endmodule

// File: tb/tb_debounce_ctrl.sv
// Bench for debounce_ctrl: two instances (default and 2-bit bounce counter) with
// attached down-counter models, checked against a run-length model of the switch rules.
module tb_debounce_ctrl;
    import debounce_pkg::*;

    localparam int unsigned   CW         = DEF_CNT_W;
    localparam logic [CW-1:0] SETTLE     = DEF_SETTLE_CNT;
    localparam int unsigned   BW         = DEF_BOUNCE_W;
    localparam int unsigned   BW_SAT     = 2;
    localparam logic          INIT       = 1'b0;
    localparam int            RUN_COMMIT = int'(SETTLE) + 1;

    logic sysclk = 1'b0;
    logic reset;
    logic sw_i;

    logic          load_a, en_a, up_a, min_a, lvl_a, rise_a, fall_a;
    logic [CW-1:0] d_a;
    logic [BW-1:0] bnc_a;
    logic          load_s, en_s, up_s, min_s, lvl_s, rise_s, fall_s;
    logic [CW-1:0] d_s;
    logic [BW_SAT-1:0] bnc_s;

    logic [CW-1:0] q_a = '0;
    logic [CW-1:0] q_s = '0;

    int n_checks = 0;
    int n_errors = 0;
    int n_rise   = 0;
    int n_fall   = 0;

    // Reference model state: synchroniser image, level, length of current mismatch run.
    logic m_s1, m_s2, m_level, m_rise, m_fall;
    int   m_run;
    int   m_aborts;
    bit   m_valid = 1'b0;

    always #5 sysclk = ~sysclk;

    debounce_ctrl #(
        .CNT_W (CW), .SETTLE_CNT (SETTLE), .INIT_LEVEL (INIT), .BOUNCE_W (BW)
    ) dut (
        .sysclk (sysclk), .reset (reset), .sw_i (sw_i),
        .cnt_load (load_a), .cnt_en (en_a), .cnt_up (up_a), .cnt_d (d_a),
        .cnt_min_tick (min_a), .db_level_o (lvl_a), .rise_tick_o (rise_a),
        .fall_tick_o (fall_a), .bounce_cnt_o (bnc_a)
    );

    debounce_ctrl #(
        .CNT_W (CW), .SETTLE_CNT (SETTLE), .INIT_LEVEL (INIT), .BOUNCE_W (BW_SAT)
    ) dut_sat (
        .sysclk (sysclk), .reset (reset), .sw_i (sw_i),
        .cnt_load (load_s), .cnt_en (en_s), .cnt_up (up_s), .cnt_d (d_s),
        .cnt_min_tick (min_s), .db_level_o (lvl_s), .rise_tick_o (rise_s),
        .fall_tick_o (fall_s), .bounce_cnt_o (bnc_s)
    );

    // External up/down counters with load priority, as on the board.
    always @(posedge sysclk) begin
        if (load_a)    q_a <= d_a;
        else if (en_a) q_a <= up_a ? q_a + 1'b1 : q_a - 1'b1;
        if (load_s)    q_s <= d_s;
        else if (en_s) q_s <= up_s ? q_s + 1'b1 : q_s - 1'b1;
    end
    assign min_a = (q_a == '0);
    assign min_s = (q_s == '0);

    // A level change needs SETTLE+2 consecutive mismatching sw_s cycles; a match ending a run is an abort.
    always @(posedge sysclk) begin
        if (reset) begin
            m_s1 <= INIT; m_s2 <= INIT; m_level <= INIT;
            m_rise <= 1'b0; m_fall <= 1'b0;
            m_run <= 0; m_aborts <= 0; m_valid <= 1'b1;
        end else begin
            m_rise <= 1'b0;
            m_fall <= 1'b0;
            if (m_s2 != m_level) begin
                if (m_run == RUN_COMMIT) begin
                    m_level <= m_s2;
                    m_rise  <= m_s2;
                    m_fall  <= ~m_s2;
                    m_run   <= 0;
                end else begin
                    m_run <= m_run + 1;
                end
            end else begin
                if (m_run != 0) m_aborts <= m_aborts + 1;
                m_run <= 0;
            end
            m_s2 <= m_s1;
            m_s1 <= sw_i;
        end
    end

    function automatic int sat_cnt(input int v, input int unsigned w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic cycle_monitor();
        logic exp_load, exp_en, diff;
        forever begin
            @(negedge sysclk);
            if (rise_a) n_rise++;
            if (fall_a) n_fall++;
            if (m_valid) begin
                diff     = (m_s2 != m_level);
                exp_load = diff && (m_run == 0);
                exp_en   = diff && (m_run >= 1) && (m_run <= int'(SETTLE));
                check_eq("cyc_level",  32'(lvl_a),  32'(m_level));
                check_eq("cyc_rise",   32'(rise_a), 32'(m_rise));
                check_eq("cyc_fall",   32'(fall_a), 32'(m_fall));
                check_eq("cyc_load",   32'(load_a), 32'(exp_load));
                check_eq("cyc_en",     32'(en_a),   32'(exp_en));
                check_eq("cyc_up",     32'(up_a),   32'(0));
                check_eq("cyc_d",      32'(d_a),    32'(SETTLE));
                check_eq("cyc_bounce", 32'(bnc_a),  32'(sat_cnt(m_aborts, BW)));
                check_eq("cyc_sat_bounce", 32'(bnc_s), 32'(sat_cnt(m_aborts, BW_SAT)));
                check_eq("cyc_sat_level",  32'(lvl_s), 32'(m_level));
            end
        end
    endtask

    task automatic do_reset();
        @(negedge sysclk);
        reset = 1'b1;
        sw_i  = INIT;
        repeat (3) @(negedge sysclk);
        reset = 1'b0;
        repeat (4) @(negedge sysclk);
    endtask

    task automatic glitch(input int hi);
        @(negedge sysclk);
        sw_i = 1'b1;
        repeat (hi) @(negedge sysclk);
        sw_i = 1'b0;
        repeat (6) @(negedge sysclk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r0, f0, load_n, load_j, en_n, lvl_j, rise_n, rise_j;
        logic [1:0] sat_exp [5];
        sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

        sw_i  = INIT;
        reset = 1'b1;
        fork cycle_monitor(); join_none

        // Reset state
        repeat (3) @(posedge sysclk);
        #1;
        check_eq("rst_level", 32'(lvl_a), 32'(INIT));
        check_eq("rst_load",  32'(load_a), 32'(0));
        check_eq("rst_en",    32'(en_a), 32'(0));
        check_eq("rst_ticks", 32'({rise_a, fall_a}), 32'(0));
        check_eq("rst_bounce", 32'(bnc_a), 32'(0));
        @(negedge sysclk);
        reset = 1'b0;
        repeat (4) @(negedge sysclk);

        // Clean rise with exact latency
        r0 = n_rise;
        @(negedge sysclk);
        sw_i = 1'b1;
        load_n = 0; load_j = -1; en_n = 0; lvl_j = -1; rise_n = 0; rise_j = -1;
        for (int j = 0; j <= 16; j++) begin
            @(posedge sysclk);
            #1;
            if (load_a) begin load_n++; load_j = j; end
            if (en_a) en_n++;
            if (lvl_a && (lvl_j < 0)) lvl_j = j;
            if (rise_a) begin rise_n++; rise_j = j; end
        end
        check_eq("rise_load_cycles", 32'(load_n), 32'(1));
        check_eq("rise_load_edge",   32'(load_j), 32'(1));
        check_eq("rise_en_cycles",   32'(en_n),   32'(SETTLE));
        check_eq("rise_level_edge",  32'(lvl_j),  32'(int'(SETTLE) + 3));
        check_eq("rise_tick_count",  32'(rise_n), 32'(1));
        check_eq("rise_tick_edge",   32'(rise_j), 32'(int'(SETTLE) + 3));
        check_eq("rise_bounce",      32'(bnc_a),  32'(0));

        // Bounce rejection
        do_reset();
        r0 = n_rise; f0 = n_fall;
        glitch(5);
        repeat (15) @(negedge sysclk);
        check_eq("bnc_level",  32'(lvl_a), 32'(0));
        check_eq("bnc_ticks",  32'((n_rise - r0) + (n_fall - f0)), 32'(0));
        check_eq("bnc_count",  32'(bnc_a), 32'(1));

        // Random bounce train ending high
        do_reset();
        r0 = n_rise; f0 = n_fall;
        @(posedge sysclk);
        #1;
        for (int i = 0; i < 15; i++) begin
            #($urandom_range(1, 20));
            if (($time % 10) == 5) #1;
            sw_i = ~sw_i;
        end
        @(posedge sysclk);
        repeat (int'(SETTLE) + 3) @(posedge sysclk);
        #1;
        check_eq("train_level_latency", 32'(lvl_a), 32'(1));
        #200;
        check_eq("train_rise_count", 32'(n_rise - r0), 32'(1));
        check_eq("train_fall_count", 32'(n_fall - f0), 32'(0));
        check_eq("train_level",      32'(lvl_a), 32'(1));
        check_eq("train_bounce",     32'(bnc_a), 32'(sat_cnt(m_aborts, BW)));

        // Abort vs commit collision
        do_reset();
        r0 = n_rise;
        @(negedge sysclk);
        sw_i = 1'b1;
        repeat (int'(SETTLE) + 1) @(negedge sysclk);
        sw_i = 1'b0;
        @(posedge sysclk);
        @(posedge sysclk);
        #1;
        check_eq("coll_min_tick", 32'(min_a), 32'(1));
        check_eq("coll_en",       32'(en_a),  32'(0));
        @(posedge sysclk);
        #1;
        check_eq("coll_level",  32'(lvl_a),  32'(0));
        check_eq("coll_rise",   32'(rise_a), 32'(0));
        check_eq("coll_bounce", 32'(bnc_a),  32'(1));
        check_eq("coll_stable", 32'({load_a, en_a}), 32'(0));
        repeat (5) @(negedge sysclk);
        check_eq("coll_ticks",  32'(n_rise - r0), 32'(0));

        // Reset five cycles into WAIT
        do_reset();
        glitch(4);
        check_eq("mid_pre_bounce", 32'(bnc_a), 32'(1));
        r0 = n_rise; f0 = n_fall;
        @(negedge sysclk);
        sw_i = 1'b1;
        repeat (7) @(negedge sysclk);
        check_eq("mid_pre_wait", 32'(en_a), 32'(1));
        reset = 1'b1;
        sw_i  = 1'b0;
        @(posedge sysclk);
        #1;
        check_eq("mid_load",   32'(load_a), 32'(0));
        check_eq("mid_en",     32'(en_a),   32'(0));
        check_eq("mid_level",  32'(lvl_a),  32'(INIT));
        check_eq("mid_bounce", 32'(bnc_a),  32'(0));
        @(negedge sysclk);
        reset = 1'b0;
        repeat (20) @(negedge sysclk);
        check_eq("mid_ticks",  32'((n_rise - r0) + (n_fall - f0)), 32'(0));

        // Saturation of the 2-bit bounce counter
        do_reset();
        for (int i = 0; i < 5; i++) begin
            glitch(3);
            check_eq("sat_bounce", 32'(bnc_s), 32'(sat_exp[i]));
            check_eq("sat_wide_bounce", 32'(bnc_a), 32'(i + 1));
        end

        // Random soak of held levels and short glitches
        do_reset();
        for (int i = 0; i < 60; i++) begin
            @(negedge sysclk);
            sw_i = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 18)) @(negedge sysclk);
        end
        sw_i = 1'b0;
        repeat (30) @(negedge sysclk);
        check_eq("soak_level",  32'(lvl_a), 32'(0));
        check_eq("soak_bounce", 32'(bnc_a), 32'(sat_cnt(m_aborts, BW)));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/debounce_ctrl.md
Name: debounce_ctrl

Overview:
- Controller that sequences an external N-bit binary counter (load/en/up/d, min_tick) as a settle timer, so a bouncing mechanical switch becomes a clean debounced level plus edge ticks.
- Sits between a board switch pin and downstream logic.
- The counter instance sits beside it at the same hierarchy level; this block owns all of the counter's control inputs.
- Also reports how many bounces it rejected, for board bring-up.

Parameters:
- CNT_W, 8: width of the counter preload value.
- SETTLE_CNT, 8'h0A: preload value. The input must stay stable for SETTLE_CNT+1 counter cycles. Legal range is 1..2^CNT_W-1.
- INIT_LEVEL, 1'b0: debounced level, and synchroniser contents, after reset.
- BOUNCE_W, 8: width of the saturating bounce counter.

Ports:
- sysclk  in  1  single system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- sw_i  in  1  raw asynchronous switch input.
- cnt_load  out  1  counter load strobe; counter takes cnt_d at the next edge.
- cnt_en  out  1  counter count enable.
- cnt_up  out  1  counter direction; constant 0 (count down).
- cnt_d  out  CNT_W  counter preload; constant SETTLE_CNT.
- cnt_min_tick  in  1  counter q==0 flag (combinational from the counter).
- db_level_o  out  1  debounced switch level.
- rise_tick_o  out  1  one-cycle pulse when db_level_o goes 0->1.
- fall_tick_o  out  1  one-cycle pulse when db_level_o goes 1->0.
- bounce_cnt_o  out  BOUNCE_W  number of aborted settle attempts since reset; saturating.

Behaviour:
- Reset (synchronous, active-high) sets:
  - sync flops = INIT_LEVEL, db_level_o = INIT_LEVEL
  - state = STABLE
  - cnt_load = 0, cnt_en = 0, both tick outputs = 0, bounce_cnt_o = 0
- Reset asserted mid-WAIT wins unconditionally: no tick is issued, and bounce_cnt_o is not incremented for that attempt.
- sw_i passes through a 2-flop synchroniser; sw_s is the second flop. All decisions use sw_s only.
- FSM states are STABLE and WAIT. Counter controls (cnt_load, cnt_en) are combinational from state and inputs.
- STABLE:
  - sw_s == db_level_o: cnt_load = 0, cnt_en = 0, stay in STABLE.
  - sw_s != db_level_o: cnt_load = 1, cnt_en = 0, go to WAIT. The counter holds SETTLE_CNT on entry to WAIT.
- WAIT, evaluated in priority order:
  - (a) sw_s == db_level_o: this is a bounce. Go to STABLE, cnt_en = 0, bounce_cnt_o += 1 unless already all-ones. Abort wins even if cnt_min_tick = 1 in the same cycle.
  - (b) cnt_min_tick = 1: commit. At the next edge db_level_o <= sw_s, the matching tick is high for exactly that one cycle, and state goes to STABLE. cnt_en = 0.
  - (c) otherwise: cnt_en = 1, stay in WAIT.
- Latency: sw_i changes and holds, first sampled at edge k. Then:
  - sw_s reflects the change after edge k+1.
  - Load happens at edge k+2.
  - db_level_o changes at edge k+SETTLE_CNT+3. With the default, that is 13 cycles.
- Ticks are registered and never overlap. At most one tick fires per commit, and commits are separated by at least SETTLE_CNT+2 cycles.
- Re-bounce after an abort: the next sw_s difference seen in STABLE reloads the counter, so the full window restarts. No partial credit carries over.
- The block never relies on the counter's value outside WAIT. Because every entry to WAIT reloads, a stale count is harmless.
- The synchroniser sits on the asynchronous path. That is its only metastability handling; no other logic samples sw_i.

Decomposition:
- debounce_pkg holds:
  - the state typedef (enum logic {STABLE, WAIT})
  - the default constants: CNT_W, SETTLE_CNT, BOUNCE_W
- One sub-module, sync_2ff: a parameterised reset value and a synchronous active-high reset. It is reused wherever the board brings in asynchronous pins.
- The counter itself is not instantiated inside this block.

Test Plan:
- Clean rise (default parameters, counter model attached, INIT_LEVEL = 0): sw_i 0->1 first sampled at edge k and held. Required:
  - cnt_load high for the single cycle before edge k+2.
  - cnt_en high for 10 cycles.
  - db_level_o = 1 from edge k+13.
  - rise_tick_o high for exactly that one cycle.
  - bounce_cnt_o = 0.
- Bounce rejection: from level 0, sw_i high for 5 cycles then back low and held. Required:
  - db_level_o stays 0.
  - no tick fires.
  - bounce_cnt_o = 1.
- Random bounce train (15 random toggles at 1-20 ns intervals) ending high, settled 200 ns. Required:
  - exactly one rise_tick_o.
  - db_level_o = 1 a final SETTLE_CNT+3 cycles after the last toggle.
  - no fall_tick_o.
  - bounce_cnt_o equals the number of aborts the scoreboard counted.
- Abort vs commit collision: sw_i returns to the old level so that sw_s reverts in the same cycle cnt_min_tick = 1. Required:
  - no commit and no tick.
  - bounce_cnt_o increments.
  - state returns to STABLE.
- Reset mid-WAIT (5 cycles into WAIT). Required:
  - next cycle: cnt_load = 0, cnt_en = 0, db_level_o = INIT_LEVEL, bounce_cnt_o = 0.
  - no tick fires.
- Saturation with BOUNCE_W = 2: 5 aborted glitches. Required: bounce_cnt_o reads 1, 2, 3, 3, 3.
